// File: rtl/sel_sweep_checker_if.sv
// Handshake/result bundle between the sweep checker and the decoder under test.
// The master side is the checker; the slave side is the decoder plus whoever issues start.
interface sel_sweep_checker_if #(
    parameter int unsigned SEL_W = 2
);
    logic             start;
    logic [SEL_W-1:0] sel;
    logic [SEL_W-1:0] out_in;
    logic             flag_in;
    logic             busy;
    logic             done;
    logic             pass;
    logic [7:0]       err_count;
    logic             fail_valid;
    logic [SEL_W-1:0] fail_sel;

    modport master (
        input  start, out_in, flag_in,
        output sel, busy, done, pass, err_count, fail_valid, fail_sel
    );

    modport slave (
        output start, out_in, flag_in,
        input  sel, busy, done, pass, err_count, fail_valid, fail_sel
    );
endinterface

// File: rtl/sel_sweep_checker.sv
// Sweeps a select code over 0..LAST, waits SETTLE cycles per step and checks that the
// decoder returns ~sel with a flag that is high exactly when the returned code is zero.
module sel_sweep_checker #(
    parameter int unsigned SEL_W  = 2,
    parameter int unsigned LAST   = 6,
    parameter int unsigned SETTLE = 1
) (
    input logic                   clk,
    input logic                   reset,
    sel_sweep_checker_if.master   bus
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_DRIVE = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_CHECK = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]       state;
    logic [7:0]       idx;
    logic [3:0]       settle_cnt;
    logic [SEL_W-1:0] sel_q;
    logic             done_q;
    logic             pass_q;
    logic [7:0]       err_q;
    logic             fail_valid_q;
    logic [SEL_W-1:0] fail_sel_q;

    logic [SEL_W-1:0] exp_code;
    logic             exp_flag;
    logic             check_fail;

    // Flag is judged against what the decoder actually returned, not against the ideal code.
    assign exp_code   = ~sel_q;
    assign exp_flag   = (bus.out_in == '0);
    assign check_fail = (bus.out_in != exp_code) || (bus.flag_in != exp_flag);

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            idx          <= 8'd0;
            settle_cnt   <= 4'd0;
            sel_q        <= '0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            err_q        <= 8'd0;
            fail_valid_q <= 1'b0;
            fail_sel_q   <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        state        <= S_DRIVE;
                        idx          <= 8'd0;
                        err_q        <= 8'd0;
                        fail_valid_q <= 1'b0;
                        fail_sel_q   <= '0;
                        done_q       <= 1'b0;
                        pass_q       <= 1'b0;
                    end
                end
                S_DRIVE: begin
                    sel_q      <= idx[SEL_W-1:0];
                    settle_cnt <= 4'(SETTLE - 1);
                    state      <= S_WAIT;
                end
                S_WAIT: begin
                    if (settle_cnt == 4'd0) begin
                        state <= S_CHECK;
                    end else begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end
                end
                S_CHECK: begin
                    if (check_fail) begin
                        if (err_q != 8'hff) begin
                            err_q <= err_q + 8'd1;
                        end
                        if (!fail_valid_q) begin
                            fail_valid_q <= 1'b1;
                            fail_sel_q   <= sel_q;
                        end
                    end
                    if (idx == 8'(LAST)) begin
                        state  <= S_DONE;
                        done_q <= 1'b1;
                        pass_q <= (err_q == 8'd0) && !check_fail;
                    end else begin
                        idx   <= idx + 8'd1;
                        state <= S_DRIVE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.sel        = sel_q;
    assign bus.busy       = (state == S_DRIVE) || (state == S_WAIT) || (state == S_CHECK);
    assign bus.done       = done_q;
    assign bus.pass       = pass_q;
    assign bus.err_count  = err_q;
    assign bus.fail_valid = fail_valid_q;
    assign bus.fail_sel   = fail_sel_q;

endmodule

// File: tb/tb_sel_sweep_checker.sv
// Scoreboarded bench: stimulus pushes expected sel steps and sweep results into queues,
// monitors pop and compare when the DUT presents a step or a completed sweep.
module tb_sel_sweep_checker;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sel_sweep_checker_if #(.SEL_W(2)) bus ();
    sel_sweep_checker_if #(.SEL_W(2)) big ();

    sel_sweep_checker #(.SEL_W(2), .LAST(6), .SETTLE(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    sel_sweep_checker #(.SEL_W(2), .LAST(254), .SETTLE(1)) dut_big (
        .clk   (clk),
        .reset (reset),
        .bus   (big)
    );

    // Decoder model: 0 ideal, 1 returns 00/flag=1 for sel=2, 2 flag stuck at 0.
    int         mode;
    logic [1:0] dec_out;
    logic       dec_flag;
    always_comb begin
        dec_out = ~bus.sel;
        if (mode == 1 && bus.sel == 2'd2) dec_out = 2'b00;
        dec_flag = (dec_out == 2'b00) && (mode != 2);
    end
    assign bus.out_in  = dec_out;
    assign bus.flag_in = dec_flag;

    // Always-wrong decoder: echoes sel, which never equals ~sel.
    assign big.out_in  = big.sel;
    assign big.flag_in = (big.sel == 2'b00);

    typedef struct {
        int err;
        int fv;
        int fs;
        int pass;
    } res_t;

    res_t res_q[$];
    res_t big_q[$];
    int   sel_exp[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic cmp_res(input string tag, input res_t r, input int err, input int fv,
                           input int fs, input int pass);
        check({tag, "_err_count"}, err, r.err);
        check({tag, "_fail_valid"}, fv, r.fv);
        check({tag, "_fail_sel"}, fs, r.fs);
        check({tag, "_pass"}, pass, r.pass);
    endtask

    // Main monitor: one sel step every 3 cycles (SETTLE=1), sampled while in CHECK.
    initial begin
        int   cyc;
        logic done_prev;
        res_t r;
        cyc       = 0;
        done_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.busy === 1'b1) begin
                if (cyc % 3 == 2 && sel_exp.size() > 0) check("sel_step", bus.sel, sel_exp.pop_front());
                cyc++;
            end else begin
                cyc = 0;
            end
            if (bus.done === 1'b1 && !done_prev) begin
                if (res_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    r = res_q.pop_front();
                    cmp_res("sweep", r, bus.err_count, bus.fail_valid, bus.fail_sel, bus.pass);
                end
            end
            done_prev = (bus.done === 1'b1);
        end
    end

    initial begin
        logic done_prev;
        res_t r;
        done_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (big.done === 1'b1 && !done_prev) begin
                if (big_q.size() == 0) begin
                    check("big_unexpected_done", 1, 0);
                end else begin
                    r = big_q.pop_front();
                    cmp_res("big", r, big.err_count, big.fail_valid, big.fail_sel, big.pass);
                end
            end
            done_prev = (big.done === 1'b1);
        end
    end

    task automatic wait_done(input string name, input int limit);
        int n;
        n = 0;
        while (bus.done !== 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
        end
        check(name, int'(bus.done === 1'b1), 1);
    endtask

    task automatic run_sweep(input int m, input int err, input int fv, input int fs,
                             input int pass);
        res_t r;
        mode = m;
        for (int i = 0; i <= 6; i++) sel_exp.push_back(i % 4);
        r = '{err: err, fv: fv, fs: fs, pass: pass};
        res_q.push_back(r);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done("sweep_done", 100);
        @(negedge clk);
    endtask

    initial begin
        res_t r;
        int   n;
        reset     = 1'b1;
        bus.start = 1'b0;
        big.start = 1'b0;
        mode      = 0;
        repeat (2) @(negedge clk);
        check("rst_sel", bus.sel, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_pass", bus.pass, 0);
        check("rst_err_count", bus.err_count, 0);
        check("rst_fail_valid", bus.fail_valid, 0);
        check("rst_fail_sel", bus.fail_sel, 0);

        // Reset wins over start on the same edge.
        bus.start = 1'b1;
        @(negedge clk);
        check("rst_over_start_busy", bus.busy, 0);
        reset     = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        check("idle_stays_idle", bus.busy, 0);

        run_sweep(0, 0, 0, 0, 1);
        run_sweep(1, 2, 1, 2, 0);
        run_sweep(2, 1, 1, 3, 0);

        // Reset during WAIT of idx 4 after a failure at idx 3.
        mode = 2;
        for (int i = 0; i < 4; i++) sel_exp.push_back(i);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (13) @(negedge clk);
        check("pre_abort_err_count", bus.err_count, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", bus.busy, 0);
        check("abort_sel", bus.sel, 0);
        check("abort_err_count", bus.err_count, 0);
        check("abort_fail_valid", bus.fail_valid, 0);
        check("abort_done", bus.done, 0);
        @(negedge clk);
        run_sweep(0, 0, 0, 0, 1);

        // start held high for a whole sweep, then restart out of DONE.
        mode = 1;
        for (int i = 0; i <= 6; i++) sel_exp.push_back(i % 4);
        r = '{err: 2, fv: 1, fs: 2, pass: 0};
        res_q.push_back(r);
        bus.start = 1'b1;
        @(negedge clk);
        wait_done("held_start_done", 100);
        @(negedge clk);
        check("restart_done", bus.done, 0);
        check("restart_busy", bus.busy, 1);
        check("restart_err_count", bus.err_count, 0);
        check("restart_fail_valid", bus.fail_valid, 0);
        reset     = 1'b1;
        bus.start = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Long sweep against an always-wrong decoder: 255 failures, no wrap.
        r = '{err: 255, fv: 1, fs: 0, pass: 0};
        big_q.push_back(r);
        big.start = 1'b1;
        @(negedge clk);
        big.start = 1'b0;
        n = 0;
        while (big.done !== 1'b1 && n < 1200) begin
            @(negedge clk);
            n++;
        end
        check("big_done", int'(big.done === 1'b1), 1);
        repeat (2) @(negedge clk);

        check("sel_queue_drained", sel_exp.size(), 0);
        check("res_queue_drained", res_q.size(), 0);
        check("big_queue_drained", big_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sel_sweep_checker.md
SEL_SWEEP_CHECKER -- requirements
Module: sel_sweep_checker

Interface
REQ-001 Parameter SEL_W, default 2, width of the select code and of the response code.
REQ-002 Parameter LAST, default 6, last sweep index; the sweep covers indices 0..LAST inclusive; legal range 0..254.
REQ-003 Parameter SETTLE, default 1, number of clk cycles the DUT is given between driving sel and sampling the response; legal range 1..15.
REQ-004 Port clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 Port reset  input  1  synchronous, active-high reset.
REQ-006 Port start  input  1  request to begin a sweep; sampled each rising edge.
REQ-007 Port sel  output  SEL_W  select code driven to the downstream decoder.
REQ-008 Port out_in  input  SEL_W  response code returned by the decoder.
REQ-009 Port flag_in  input  1  decoder flag, expected high when the response code is all-zero.
REQ-010 Port busy  output  1  high while a sweep is in progress.
REQ-011 Port done  output  1  high from sweep completion until the next start or reset.
REQ-012 Port pass  output  1  valid when done=1; high iff err_count=0.
REQ-013 Port err_count  output  8  number of failing checks in the current or last sweep; saturates at 255.
REQ-014 Port fail_valid  output  1  high once any check has failed in the current or last sweep.
REQ-015 Port fail_sel  output  SEL_W  sel value of the first failing check; meaningful only when fail_valid=1.

Function
REQ-016 The block SHALL implement the FSM states IDLE, DRIVE, WAIT, CHECK and DONE.
REQ-017 In IDLE or DONE, start=1 SHALL clear idx, err_count, fail_valid, fail_sel and done, and SHALL move the FSM to DRIVE on the next edge.
REQ-018 The block SHALL ignore start while busy=1, with no restart and no state change.
REQ-019 In DRIVE, the block SHALL register sel = idx[SEL_W-1:0], with higher idx bits wrapping, load the settle counter with SETTLE-1, and move to WAIT.
REQ-020 WAIT SHALL hold sel stable and decrement the settle counter, then move to CHECK on the edge where the counter is 0.
REQ-021 Sampling latency SHALL be exactly SETTLE+1 edges from sel update to CHECK sampling out_in and flag_in.
REQ-022 In CHECK, the expected code SHALL be ~sel (bitwise, SEL_W bits).
REQ-023 In CHECK, the expected flag SHALL be 1 when out_in equals 0, else 0; the flag SHALL be judged against the received out_in.
REQ-024 A check SHALL fail if out_in differs from the expected code or flag_in differs from the expected flag.
REQ-025 A failing check SHALL increment err_count, saturating at 255, with no wrap to 0.
REQ-026 On the first failure of a sweep, the block SHALL set fail_valid=1 and capture fail_sel=sel; later failures SHALL NOT overwrite fail_sel.
REQ-027 After CHECK, if idx equals LAST the FSM SHALL move to DONE; otherwise it SHALL increment idx and return to DRIVE.
REQ-028 idx SHALL be 8 bits wide and SHALL NOT wrap during a legal sweep.
REQ-029 busy SHALL equal 1 in DRIVE, WAIT and CHECK, and 0 in IDLE and DONE.
REQ-030 done SHALL rise on entry to DONE and stay high until start or reset; pass SHALL be registered together with done.
REQ-031 If start and a CHECK failure coincide, the failure SHALL be counted; start is ignored per REQ-018.
REQ-032 With LAST=0, the sweep SHALL consist of a single DRIVE/WAIT/CHECK pass at sel=0.

Reset
REQ-033 reset=1 at a rising edge SHALL force the FSM to IDLE regardless of state, including mid-sweep.
REQ-034 Reset values SHALL be: sel=0, busy=0, done=0, pass=0, err_count=0, fail_valid=0, fail_sel=0, idx=0, settle counter=0.
REQ-035 reset SHALL take priority over start on the same edge.
REQ-036 After a mid-sweep reset, no partial results SHALL be visible; the next start SHALL begin at idx=0.

Verification
REQ-037 Defaults with an ideal decoder (0->11, 1->10, 2->01, 3->00, flag=(out==00)); pulse start -> sel sequence 0,1,2,3,0,1,2 at one step per 3 cycles (SETTLE=1) -> done=1, pass=1, err_count=0, fail_valid=0.
REQ-038 Decoder forced to return 00 for sel=2 with flag=1 -> err_count=2 (sel=2 at idx 2 and 6), fail_valid=1, fail_sel=2, pass=0.
REQ-039 Decoder correct except flag stuck at 0 -> failures only at sel=3 (idx 3) -> err_count=1, fail_sel=3.
REQ-040 Assert reset during WAIT of idx 4 -> next edge: busy=0, sel=0, err_count=0; new start then completes a full 7-step sweep, done=1.
REQ-041 start held high throughout a sweep -> exactly one sweep runs; once in DONE, start restarts it and clears done and err_count on the next edge.
REQ-042 LAST=254, SEL_W=2, decoder always wrong -> err_count saturates at 255 without wrapping, fail_sel=0.
